regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_rd_port.sv | 44 ++++
 rtl/regfile_mp.sv | 114 +++++++++++
 tb/tb_regfile_mp.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared state encoding and default sizing for the regfile_mp block.
// Revision : 1.0
// ============================================================================
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// ============================================================================
// Module   : regfile_rd_port
// Brief    : One combinational read port with reg-0, busy and optional
//            write-first forcing (REGFILE_BYPASS_EN).
// Revision : 1.0
// ============================================================================
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic [XLEN-1:0] regs_i [NREGS],
    input  logic [AW-1:0]   rd_addr_i,
    input  logic            busy_i,
    input  logic            wr_fire_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i,
    output logic [XLEN-1:0] rd_data_o
);

    always_comb begin
        rd_data_o = regs_i[rd_addr_i];
`ifdef REGFILE_BYPASS_EN
        if (wr_fire_i && (rd_addr_i == wr_addr_i)) begin
            rd_data_o = wr_data_i;
        end
`endif
        // Forcing last so neither bypass nor stale storage can leak through.
        if (busy_i || (rd_addr_i == '0)) begin
            rd_data_o = '0;
        end
    end

`ifdef REGFILE_BYPASS_EN
`else
    logic w_unused_bypass;
    assign w_unused_bypass = ^{wr_fire_i, wr_addr_i, wr_data_i};
`endif

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Multi-read-port register file with sequential clear FSM.
//            Optional write-first bypass via macro REGFILE_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_req,
    input  logic                we,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic                busy,
    output logic                wr_drop
);

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            wr_drop_q, wr_drop_d;
    logic [XLEN-1:0] mem_q [NREGS];

    logic            w_wr_fire;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_waddr;
    logic [XLEN-1:0] w_mem_wdata;

    assign w_wr_fire = (state_q == READY) && we && (wr_addr != '0) && !clr_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        w_mem_we    = 1'b0;
        w_mem_waddr = wr_addr;
        w_mem_wdata = wr_data;
        // Writes to register 0 are silently ignored, so they never flag a drop.
        wr_drop_d   = we && (wr_addr != '0) && ((state_q == CLEAR) || clr_req);
        case (state_q)
            CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_waddr = cnt_q;
                w_mem_wdata = '0;
                cnt_d       = cnt_q + 1'b1;
                if (clr_req) begin
                    cnt_d = '0;
                end else if (cnt_q == AW'(NREGS - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    w_mem_we = w_wr_fire;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Storage has no reset; the clear sequence zeroes it after rst_n rises.
    always_ff @(posedge clk) begin
        if (rst_n && w_mem_we) begin
            mem_q[w_mem_waddr] <= w_mem_wdata;
        end
    end

    assign busy    = (state_q == CLEAR);
    assign wr_drop = wr_drop_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rd_port
        regfile_rd_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_rd_port (
            .regs_i    (mem_q),
            .rd_addr_i (rd_addr[i*AW +: AW]),
            .busy_i    (busy),
            .wr_fire_i (w_wr_fire),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .rd_data_o (rd_data[i*XLEN +: XLEN])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Directed self-checking bench for regfile_mp (default sizing).
// Revision : 1.0
// ============================================================================
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                clr_req;
    logic                we;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic                busy;
    logic                wr_drop;

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .wr_drop (wr_drop)
    );

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd_push(input string tag, input int port, input logic [AW-1:0] addr,
                           input logic [31:0] val);
        exp_t e;
        rd_addr[port*AW +: AW] = addr;
        e.tag  = tag;
        e.port = port;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic rd_check();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, rd_data[e.port*XLEN +: XLEN], e.val);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk(tag, 32'(n), 32'd32);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [31:0] byp_exp;

        rst_n = 1'b0; clr_req = 1'b0; we = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_drop", 32'(wr_drop), 32'd0);
        rd_push("rst_rd0", 0, 5'd5, 32'h0);
        rd_push("rst_rd1", 1, 5'd0, 32'h0);
        rd_check();

        rst_n = 1'b1;
        wait_ready("init_busy_len");
        chk("init_busy_low", 32'(busy), 32'd0);
        rd_push("init_rd0", 0, 5'd31, 32'h0);
        rd_push("init_rd1", 1, 5'd17, 32'h0);
        rd_check();

        // Basic write, read on both ports next cycle
        we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        @(negedge clk);
        we = 1'b0;
        rd_push("w5_p0", 0, 5'd5, 32'hDEADBEEF);
        rd_push("w5_p1", 1, 5'd5, 32'hDEADBEEF);
        rd_check();
        chk("w5_drop", 32'(wr_drop), 32'd0);

        // Register 0 write is ignored and not a drop
        we = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
        rd_push("r0_same", 0, 5'd0, 32'h0);
        rd_check();
        @(negedge clk);
        we = 1'b0;
        rd_push("r0_after", 0, 5'd0, 32'h0);
        rd_check();
        chk("r0_drop", 32'(wr_drop), 32'd0);

        // Same-cycle read of the register being written
        we = 1'b1; wr_addr = 5'd7; wr_data = 32'h11;
        @(negedge clk);
        wr_data = 32'hA5A5A5A5;
`ifdef REGFILE_BYPASS_EN
        byp_exp = 32'hA5A5A5A5;
`else
        byp_exp = 32'h11;
`endif
        rd_push("byp_p0", 0, 5'd7, byp_exp);
        rd_push("byp_p1", 1, 5'd5, 32'hDEADBEEF);
        rd_check();
        @(negedge clk);
        we = 1'b0;
        rd_push("byp_after", 0, 5'd7, 32'hA5A5A5A5);
        rd_check();

        // Fill every register
        for (int i = 1; i < NREGS; i++) begin
            we = 1'b1; wr_addr = i[AW-1:0]; wr_data = 32'h1000 + i;
            @(negedge clk);
        end
        we = 1'b0;
        rd_push("fill_r3", 0, 5'd3, 32'h1003);
        rd_push("fill_r31", 1, 5'd31, 32'h101F);
        rd_check();

        // Clear request with a write attempted in cycle 10 of the clear
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (n == 5) begin
                rd_push("clr_rd_busy", 0, 5'd31, 32'h0);
                rd_check();
            end
            if (n == 10) begin
                we = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFFFFFF;
            end else begin
                we = 1'b0;
            end
            if (n == 11) chk("clr_drop_set", 32'(wr_drop), 32'd1);
            if (n == 12) chk("clr_drop_clr", 32'(wr_drop), 32'd0);
            @(negedge clk);
        end
        we = 1'b0;
        chk("clr_busy_len", 32'(n), 32'd32);
        rd_push("clr_r3", 0, 5'd3, 32'h0);
        rd_push("clr_r31", 1, 5'd31, 32'h0);
        rd_check();

        // Write coincident with clr_req is dropped
        we = 1'b1; wr_addr = 5'd9; wr_data = 32'h99; clr_req = 1'b1;
        @(negedge clk);
        we = 1'b0; clr_req = 1'b0;
        chk("coin_drop", 32'(wr_drop), 32'd1);
        chk("coin_busy", 32'(busy), 32'd1);
        wait_ready("coin_busy_len");

        // Reset at cnt = 20 restarts the clear and discards the write
        we = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
        @(negedge clk);
        we = 1'b0;
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0; we = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
        @(negedge clk);
        rst_n = 1'b1; we = 1'b0;
        chk("rstmid_drop", 32'(wr_drop), 32'd0);
        wait_ready("rstmid_busy_len");
        rd_push("rstmid_r4", 0, 5'd4, 32'h0);
        rd_push("rstmid_r6", 1, 5'd6, 32'h0);
        rd_check();

        // Normal operation resumes after the restarted clear
        we = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
        @(negedge clk);
        we = 1'b0;
        rd_push("post_r6", 1, 5'd6, 32'h66);
        rd_check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
